sd_cmd_responder: RTL
=====================

# sd_cmd_responder

Card-side responder for the SD CMD line: deserialises 48-bit host command frames, checks CRC7, tracks a reduced card state machine and serialises the matching response (R1/R3/R6/R7) back to the host. It is the device end of the command path driven by `sdc_controller`. It is intended for the card model in simulation and for an on-FPGA loopback card. Decoded commands are also presented to the data-path model so it can start block reads.

## Interface
Parameters:
- `NCR`, 2 — clocks from the command end bit to the response start bit; legal range 2..64.
- `RCA`, 16'h0013 — relative card address published in R6.
- `OCR`, 32'hC0FF_8000 — value returned in R3; bit 31 (busy-done) is forced to 1.

Ports:
- `clk` in 1 — SD bus clock (host `sd_clk`); all logic on rising edge.
- `rstn_async` in 1 — asynchronous, active-low reset.
- `cmd_in` in 1 — CMD line as driven by host; idle high.
- `cmd_out` out 1 — response bit; 1 whenever not driving.
- `cmd_oe` out 1 — high while a response is on the line.
- `cmd_valid` out 1 — one-cycle pulse per accepted (CRC-good, legal) command.
- `cmd_index` out 6 — index of last accepted command.
- `cmd_arg` out 32 — argument of last accepted command.
- `card_state` out 4 — current state, SD encoding.

## Operation
- Frame: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1; MSB first. CRC7 polynomial x^7+x^3+1, seed 0, computed over the first 40 bits.
- FSM: `RX_IDLE` → (cmd_in=0) `RX_SHIFT` (47 more bits) → `CHECK` → `WAIT_NCR` → `TX_SHIFT` → `RX_IDLE`. `CHECK` → `RX_IDLE` directly when no response is due.
- Transmission bit 0 in a received frame: the frame is discarded silently.
- CRC mismatch or end bit 0: no response; set `com_crc_err` (R1 status bit 23). The flag is reported in the next R1 and then cleared.
- Card states: idle(0), ready(1), ident(2), stby(3), tran(4).
- CMD0: no response; go to idle; clear app_cmd. Accepted in every state.
- CMD8: R7, which echoes arg[11:0] under index 8.
- CMD55: R1; set app_cmd (bit 5) for the next command only.
- ACMD41 (41 with app_cmd set): R3 with `OCR`, index field 6'h3F, CRC field 7'h7F; go idle→ready.
- CMD2: ready→ident; R2 is not supported (no response).
- CMD3: R6 {RCA, 16'h0000 status}; ident→stby.
- CMD7: arg[31:16]==RCA: R1, stby→tran. Otherwise: tran→stby, no response.
- CMD13, CMD16, CMD17: R1; legal only in tran.
- Illegal command (unknown index, or wrong state): no response; set illegal (bit 22), reported in the next R1.
- R1 status: {com_crc_err[23], illegal[22], 9'b0, state[12:9], ready_for_data[8]=1, 2'b0, app_cmd[5], 5'b0}. The state field holds the state before the command executes.
- Response frame: start 0, transmission 0, 6-bit index, 32-bit payload, CRC7, end 1.
- `cmd_valid`, `cmd_index` and `cmd_arg` update for every CRC-good command, including illegal ones and CMD0.

## Timing
- Reset values: `cmd_out`=1, `cmd_oe`=0, `cmd_valid`=0, `cmd_index`=0, `cmd_arg`=0, `card_state`=idle. All flags are 0 and the FSM is in `RX_IDLE`.
- End bit sampled at edge E. `cmd_valid` is high for the cycle after E+1. On edge E+NCR, `cmd_oe` rises and the start bit is driven. The response occupies 48 cycles; `cmd_oe` falls after the end bit.
- `cmd_in` is ignored from edge E until `cmd_oe` falls, plus 1 cycle (NRC guard). A host start bit arriving during this window is lost, not queued.
- Reset asserted mid-frame or mid-response: outputs go to their reset values immediately (asynchronously). The partial frame is dropped.

## Structure
- Shared package `sd_pkg`:
  - command index constants (CMD0/2/3/7/8/13/16/17/41/55);
  - `card_state_t` enum;
  - R1 status bit positions;
  - the CRC7 polynomial constant.
- Sub-module `sd_crc7`: serial CRC7 with enable and clear inputs. Instantiate it once for RX and once for TX.

## Test plan
- CMD0 frame 0x40_0000_0000_95 → no `cmd_oe` within 100 cycles; `card_state`=0; `cmd_valid` pulses with index 0.
- CMD8 frame 0x48_0000_01AA_87 → after NCR, line carries 0x08_0000_01AA_13 (with end bit); `cmd_oe` is high for exactly 48 cycles.
- CMD0 frame with CRC byte 0x97 → no response. Then CMD55 arg 0 → R1 status 0x0080_0120. A second CMD55 → status 0x0000_0120.
- Full init: CMD55, ACMD41, CMD2, CMD3, then CMD7 arg 0x0013_0000 → R6 payload 0x0013_0000; final R1 state field=3; `card_state`=4.
- CMD17 while idle → no response. Next CMD55 status has bit 22 set (0x0040_0120).
- Reset pulse mid-response (cycle 20 of TX) → `cmd_oe`=0, `cmd_out`=1 the same cycle. A subsequent CMD8 answers normally.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants, card-state encoding and R1 status packing for the SD command path.
// Latency: none (package only).
// Backpressure: not applicable.
package sd_pkg;

    // Command indices handled by the card model
    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD2  = 6'd2;
    localparam logic [5:0] CMD3  = 6'd3;
    localparam logic [5:0] CMD7  = 6'd7;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD13 = 6'd13;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    // Card states in SD CURRENT_STATE encoding
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_READY = 4'd1,
        ST_IDENT = 4'd2,
        ST_STBY  = 4'd3,
        ST_TRAN  = 4'd4
    } card_state_t;

    // R1 card-status bit positions
    localparam int R1_COM_CRC_ERR    = 23;
    localparam int R1_ILLEGAL        = 22;
    localparam int R1_STATE_LSB      = 9;
    localparam int R1_READY_FOR_DATA = 8;
    localparam int R1_APP_CMD        = 5;

    // x^7 + x^3 + 1 (the x^7 term is implicit in the shift)
    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [31:0] r1_status(input logic       crc_err,
                                              input logic       illegal,
                                              input logic [3:0] state,
                                              input logic       app_cmd);
        logic [31:0] s;
        s = '0;
        s[R1_COM_CRC_ERR]         = crc_err;
        s[R1_ILLEGAL]             = illegal;
        s[R1_STATE_LSB +: 4]      = state;
        s[R1_READY_FOR_DATA]      = 1'b1;
        s[R1_APP_CMD]             = app_cmd;
        return s;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, zero seed), one bit per enabled clock, MSB first.
// Latency: crc_o reflects a bit on the clock after it is presented with en_i high.
// Backpressure: none; clr_i has priority over en_i.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rstn_async,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    // Next CRC: clear, or shift one bit through the polynomial
    always_comb begin
        fb    = din_i ^ crc_q[6];
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    // CRC register
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) crc_q <= '0;
        else             crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD responder: receives 48-bit commands, checks CRC7, runs the card state machine, sends R1/R3/R6/R7.
// Latency: cmd_valid one cycle after the end bit; response start bit NCR cycles after the end bit, 48 bits long.
// Backpressure: none; host start bits arriving while busy (through one cycle after cmd_oe falls) are dropped.
module sd_cmd_responder #(
    parameter int unsigned NCR = 2,
    parameter logic [15:0] RCA = 16'h0013,
    parameter logic [31:0] OCR = 32'hC0FF_8000
) (
    input  logic        clk,
    input  logic        rstn_async,
    input  logic        cmd_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic [3:0]  card_state
);
    import sd_pkg::*;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_SHIFT = 3'd1;
    localparam logic [2:0] CHECK    = 3'd2;
    localparam logic [2:0] WAIT_NCR = 3'd3;
    localparam logic [2:0] TX_SHIFT = 3'd4;

    // CHECK occupies the first cycle after the end bit, WAIT_NCR the rest minus the launch edge
    localparam logic [5:0] NCR_WAIT = 6'(NCR - 2);

    logic [2:0]  fsm_q, fsm_d;
    logic [46:0] rx_sr_q, rx_sr_d;      // start bit is shifted out; [46]=trans ... [0]=end
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;    // NCR countdown, then index of the bit on the line
    logic        guard_q, guard_d;
    logic        cmd_out_q, cmd_out_d;
    logic        cmd_oe_q, cmd_oe_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    card_state_t card_state_q, card_state_d;
    logic        crc_err_q, crc_err_d;
    logic        illegal_q, illegal_d;
    logic        app_cmd_q, app_cmd_d;
    logic [5:0]  resp_idx_q, resp_idx_d;
    logic [31:0] resp_pay_q, resp_pay_d;
    logic        resp_r3_q, resp_r3_d;

    logic        rx_crc_clr, rx_crc_en, tx_crc_clr, tx_crc_en;
    logic [6:0]  rx_crc, tx_crc;
    logic [5:0]  rx_idx, tx_k;
    logic [31:0] rx_arg;
    logic [39:0] tx_frame;
    logic        tx_bit, legal, r1_due, resp_due;

    assign rx_idx     = rx_sr_q[45:40];
    assign rx_arg     = rx_sr_q[39:8];
    assign tx_frame   = {2'b00, resp_idx_q, resp_pay_q};
    assign tx_crc_clr = (fsm_q == CHECK);

    sd_crc7 u_rx_crc (
        .clk        (clk),
        .rstn_async (rstn_async),
        .clr_i      (rx_crc_clr),
        .en_i       (rx_crc_en),
        .din_i      (cmd_in),
        .crc_o      (rx_crc)
    );

    sd_crc7 u_tx_crc (
        .clk        (clk),
        .rstn_async (rstn_async),
        .clr_i      (tx_crc_clr),
        .en_i       (tx_crc_en),
        .din_i      (tx_bit),
        .crc_o      (tx_crc)
    );

    // Select the response bit to launch on this edge: header/payload, CRC field, then end bit
    always_comb begin
        tx_k   = (fsm_q == WAIT_NCR) ? 6'd47 : (tx_cnt_q - 6'd1);
        tx_bit = 1'b1;
        if (tx_k <= 6'd47 && tx_k >= 6'd8) begin
            tx_bit = tx_frame[6'(tx_k - 6'd8)];
        end else if (tx_k >= 6'd1 && tx_k <= 6'd7) begin
            tx_bit = resp_r3_q ? 1'b1 : tx_crc[3'(tx_k - 6'd1)];
        end
    end

    // Receive, decode, card-state update and response sequencing
    always_comb begin
        fsm_d        = fsm_q;
        rx_sr_d      = rx_sr_q;
        rx_cnt_d     = rx_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        guard_d      = guard_q;
        cmd_out_d    = cmd_out_q;
        cmd_oe_d     = cmd_oe_q;
        cmd_valid_d  = 1'b0;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        card_state_d = card_state_q;
        crc_err_d    = crc_err_q;
        illegal_d    = illegal_q;
        app_cmd_d    = app_cmd_q;
        resp_idx_d   = resp_idx_q;
        resp_pay_d   = resp_pay_q;
        resp_r3_d    = resp_r3_q;
        rx_crc_clr   = 1'b0;
        rx_crc_en    = 1'b0;
        tx_crc_en    = 1'b0;
        legal        = 1'b1;
        r1_due       = 1'b0;
        resp_due     = 1'b0;

        case (fsm_q)
            RX_IDLE: begin
                rx_crc_clr = 1'b1;
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!cmd_in) begin
                    rx_crc_clr = 1'b0;
                    rx_crc_en  = 1'b1;
                    rx_sr_d    = {rx_sr_q[45:0], cmd_in};
                    rx_cnt_d   = 6'd0;
                    fsm_d      = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                rx_sr_d   = {rx_sr_q[45:0], cmd_in};
                rx_crc_en = (rx_cnt_q < 6'd39);
                rx_cnt_d  = rx_cnt_q + 6'd1;
                if (rx_cnt_q == 6'd46) fsm_d = CHECK;
            end
            CHECK: begin
                rx_crc_clr = 1'b1;
                fsm_d      = RX_IDLE;
                tx_cnt_d   = NCR_WAIT;
                if (rx_sr_q[46]) begin
                    if (rx_crc != rx_sr_q[7:1] || !rx_sr_q[0]) begin
                        crc_err_d = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_index_d = rx_idx;
                        cmd_arg_d   = rx_arg;
                        app_cmd_d   = 1'b0;
                        resp_r3_d   = 1'b0;
                        case (rx_idx)
                            CMD0: card_state_d = ST_IDLE;
                            CMD8: begin
                                if (card_state_q == ST_IDLE) begin
                                    resp_due   = 1'b1;
                                    resp_idx_d = CMD8;
                                    resp_pay_d = {20'h0_0000, rx_arg[11:0]};
                                end else legal = 1'b0;
                            end
                            CMD55: begin
                                app_cmd_d = 1'b1;
                                r1_due    = 1'b1;
                            end
                            CMD41: begin
                                if (app_cmd_q && (card_state_q == ST_IDLE || card_state_q == ST_READY)) begin
                                    card_state_d = ST_READY;
                                    resp_due     = 1'b1;
                                    resp_r3_d    = 1'b1;
                                    resp_idx_d   = 6'h3F;
                                    resp_pay_d   = OCR | 32'h8000_0000;
                                end else legal = 1'b0;
                            end
                            CMD2: begin
                                if (card_state_q == ST_READY) card_state_d = ST_IDENT;
                                else legal = 1'b0;
                            end
                            CMD3: begin
                                if (card_state_q == ST_IDENT || card_state_q == ST_STBY) begin
                                    card_state_d = ST_STBY;
                                    resp_due     = 1'b1;
                                    resp_idx_d   = CMD3;
                                    resp_pay_d   = {RCA, 16'h0000};
                                end else legal = 1'b0;
                            end
                            CMD7: begin
                                if (rx_arg[31:16] == RCA) begin
                                    if (card_state_q == ST_STBY || card_state_q == ST_TRAN) begin
                                        card_state_d = ST_TRAN;
                                        r1_due       = 1'b1;
                                    end else legal = 1'b0;
                                end else if (card_state_q == ST_TRAN) begin
                                    card_state_d = ST_STBY;
                                end else if (card_state_q != ST_STBY) begin
                                    legal = 1'b0;
                                end
                            end
                            CMD13, CMD16, CMD17: begin
                                if (card_state_q == ST_TRAN) r1_due = 1'b1;
                                else legal = 1'b0;
                            end
                            default: legal = 1'b0;
                        endcase
                        if (!legal) illegal_d = 1'b1;
                        // R1 reports flags raised by earlier commands, then clears them
                        if (r1_due) begin
                            resp_due   = 1'b1;
                            resp_idx_d = rx_idx;
                            resp_pay_d = r1_status(crc_err_q, illegal_q, card_state_q, app_cmd_d);
                            crc_err_d  = 1'b0;
                            illegal_d  = 1'b0;
                        end
                        if (resp_due) fsm_d = WAIT_NCR;
                    end
                end
            end
            WAIT_NCR: begin
                if (tx_cnt_q == 6'd0) begin
                    fsm_d     = TX_SHIFT;
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = tx_bit;
                    tx_crc_en = 1'b1;
                    tx_cnt_d  = 6'd47;
                end else begin
                    tx_cnt_d = tx_cnt_q - 6'd1;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q == 6'd0) begin
                    cmd_oe_d  = 1'b0;
                    cmd_out_d = 1'b1;
                    guard_d   = 1'b1;
                    fsm_d     = RX_IDLE;
                end else begin
                    cmd_out_d = tx_bit;
                    tx_crc_en = (tx_k >= 6'd8);
                    tx_cnt_d  = tx_cnt_q - 6'd1;
                end
            end
            default: fsm_d = RX_IDLE;
        endcase
    end

    // State registers; reset returns the line to idle immediately
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            fsm_q        <= RX_IDLE;
            rx_sr_q      <= '0;
            rx_cnt_q     <= '0;
            tx_cnt_q     <= '0;
            guard_q      <= 1'b0;
            cmd_out_q    <= 1'b1;
            cmd_oe_q     <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_index_q  <= '0;
            cmd_arg_q    <= '0;
            card_state_q <= ST_IDLE;
            crc_err_q    <= 1'b0;
            illegal_q    <= 1'b0;
            app_cmd_q    <= 1'b0;
            resp_idx_q   <= '0;
            resp_pay_q   <= '0;
            resp_r3_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            rx_sr_q      <= rx_sr_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            guard_q      <= guard_d;
            cmd_out_q    <= cmd_out_d;
            cmd_oe_q     <= cmd_oe_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            card_state_q <= card_state_d;
            crc_err_q    <= crc_err_d;
            illegal_q    <= illegal_d;
            app_cmd_q    <= app_cmd_d;
            resp_idx_q   <= resp_idx_d;
            resp_pay_q   <= resp_pay_d;
            resp_r3_q    <= resp_r3_d;
        end
    end

    assign cmd_out    = cmd_out_q;
    assign cmd_oe     = cmd_oe_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_index  = cmd_index_q;
    assign cmd_arg    = cmd_arg_q;
    assign card_state = card_state_q;

endmodule
